// File: rtl/gate_sensor_conditioner_if.sv
// -----------------------------------------------------------------------------
// gate_sensor_conditioner_if
// Groups the beam sensor inputs and the conditioned outputs of the gate sensor
// conditioner into one bundle.
//   master : drives RAW_A/RAW_B and observes the conditioned outputs
//            (sensor front-end / parking-lot FSM side)
//   slave  : the conditioner itself
// Signals:
//   RAW_A, RAW_B        raw asynchronous beam signals, 1 = beam interrupted
//   A_LVL, B_LVL        debounced levels
//   A_RISE, A_FALL      one-cycle pulses on accepted A transitions
//   B_RISE, B_FALL      one-cycle pulses on accepted B transitions
//   BOTH_CHG            one-cycle pulse when both levels change on one edge
//   BLOCKED             a beam has been interrupted for too long
// -----------------------------------------------------------------------------
interface gate_sensor_conditioner_if;
  logic RAW_A;
  logic RAW_B;
  logic A_LVL;
  logic B_LVL;
  logic A_RISE;
  logic A_FALL;
  logic B_RISE;
  logic B_FALL;
  logic BOTH_CHG;
  logic BLOCKED;

  modport master (
    output RAW_A, RAW_B,
    input  A_LVL, B_LVL, A_RISE, A_FALL, B_RISE, B_FALL, BOTH_CHG, BLOCKED
  );

  modport slave (
    input  RAW_A, RAW_B,
    output A_LVL, B_LVL, A_RISE, A_FALL, B_RISE, B_FALL, BOTH_CHG, BLOCKED
  );
endinterface

// File: rtl/gate_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// gate_sensor_conditioner
// Input conditioning for the parking-lot gate beams. Each raw beam is passed
// through a two-flop synchroniser and a debouncer that accepts a new level only
// after DB_CYCLES consecutive mismatching samples. Accepted transitions produce
// one-cycle RISE/FALL pulses; simultaneous A/B acceptance raises BOTH_CHG. A
// block monitor raises BLOCKED when either level stays high too long.
// Ports:
//   CLOCK_50  system clock, all flops on its rising edge
//   RSTN      synchronous active-low reset, clears every flop
//   sens      slave side of gate_sensor_conditioner_if (RAW_* in, status out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module gate_sensor_conditioner #(
  parameter int DB_CYCLES    = 250000,
  parameter int CNT_W        = 18,
  parameter int BLOCK_CYCLES = 50000000,
  parameter int BLK_W        = 26
) (
  input  logic                      CLOCK_50,
  input  logic                      RSTN,
  gate_sensor_conditioner_if.slave  sens
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_CYCLES - 1);

  // Channel index 0 = A (outer beam), 1 = B (inner beam).
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            rise_q, rise_d;
  logic [1:0]            fall_q, fall_d;
  logic                  both_q, both_d;

  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  blk_full_q, blk_full_d;
  logic                  blocked_q, blocked_d;
  logic                  blk_any;

  // Debounce: any sample matching the current level discards the partial count,
  // so a glitch never lets a later mismatch finish early.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_d[i]  = lvl_q[i];
      cnt_d[i]  = '0;
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    both_d = (rise_d[0] | fall_d[0]) & (rise_d[1] | fall_d[1]);
  end

  // Block monitor on registered levels. blk_full_q marks that the counter was
  // already saturated on the previous high sample, which places the first
  // BLOCKED edge on the BLOCK_CYCLES+1-th consecutive high sample.
  always_comb begin
    blk_any    = lvl_q[0] | lvl_q[1];
    blk_cnt_d  = '0;
    blk_full_d = 1'b0;
    blocked_d  = 1'b0;
    if (blk_any) begin
      blk_cnt_d  = (blk_cnt_q == BLK_LAST) ? blk_cnt_q : blk_cnt_q + BLK_W'(1);
      blk_full_d = (blk_cnt_q == BLK_LAST);
      blocked_d  = blk_full_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RSTN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      cnt_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      both_q     <= 1'b0;
      blk_cnt_q  <= '0;
      blk_full_q <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      sync1_q    <= {sens.RAW_B, sens.RAW_A};
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      cnt_q      <= cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      both_q     <= both_d;
      blk_cnt_q  <= blk_cnt_d;
      blk_full_q <= blk_full_d;
      blocked_q  <= blocked_d;
    end
  end

  assign sens.A_LVL    = lvl_q[0];
  assign sens.B_LVL    = lvl_q[1];
  assign sens.A_RISE   = rise_q[0];
  assign sens.A_FALL   = fall_q[0];
  assign sens.B_RISE   = rise_q[1];
  assign sens.B_FALL   = fall_q[1];
  assign sens.BOTH_CHG = both_q;
  assign sens.BLOCKED  = blocked_q;

endmodule

// File: tb/tb_gate_sensor_conditioner.sv
module tb_gate_sensor_conditioner;

  localparam logic [4:0] AR = 5'b00001;
  localparam logic [4:0] AF = 5'b00010;
  localparam logic [4:0] BR = 5'b00100;
  localparam logic [4:0] BF = 5'b01000;
  localparam logic [4:0] BO = 5'b10000;

  typedef struct {
    int         t;
    logic [4:0] p;
    logic       a;
    logic       b;
    logic       k;
  } ev_t;

  logic clk = 1'b0;
  logic RSTN;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  expq[$];

  gate_sensor_conditioner_if gif ();

  gate_sensor_conditioner #(
    .DB_CYCLES   (4),
    .CNT_W       (18),
    .BLOCK_CYCLES(32),
    .BLK_W       (26)
  ) dut (
    .CLOCK_50(clk),
    .RSTN    (RSTN),
    .sens    (gif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic exp_ev(input int t, input logic [4:0] p, input logic a,
                        input logic b, input logic k);
    ev_t e;
    e.t = t; e.p = p; e.a = a; e.b = b; e.k = k;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  // Monitor: every cycle with a pulse or a BLOCKED change is one DUT event,
  // matched against the next expected event in order.
  initial begin
    logic [4:0] pulses;
    logic       blk_prev;
    logic       blk_chg;
    ev_t        e;
    blk_prev = 1'b0;
    forever begin
      @(negedge clk);
      pulses  = {gif.BOTH_CHG, gif.B_FALL, gif.B_RISE, gif.A_FALL, gif.A_RISE};
      blk_chg = (gif.BLOCKED !== blk_prev);
      blk_prev = gif.BLOCKED;
      if (pulses != 5'b0 || blk_chg) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event@%0d: got pulses=%b a=%b b=%b blk=%b, required no event",
                   cyc, pulses, gif.A_LVL, gif.B_LVL, gif.BLOCKED);
        end else begin
          e = expq.pop_front();
          if (e.t != cyc || e.p !== pulses || e.a !== gif.A_LVL ||
              e.b !== gif.B_LVL || e.k !== gif.BLOCKED) begin
            errors++;
            $display("FAIL event@%0d: got pulses=%b a=%b b=%b blk=%b, required cycle=%0d pulses=%b a=%b b=%b blk=%b",
                     cyc, pulses, gif.A_LVL, gif.B_LVL, gif.BLOCKED,
                     e.t, e.p, e.a, e.b, e.k);
          end
        end
      end
    end
  end

  initial begin
    int b;
    RSTN = 1'b0;
    gif.RAW_A = 1'b1;
    gif.RAW_B = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state with both raw beams high
    chk("rst_A_LVL",    gif.A_LVL,    1'b0);
    chk("rst_B_LVL",    gif.B_LVL,    1'b0);
    chk("rst_A_RISE",   gif.A_RISE,   1'b0);
    chk("rst_A_FALL",   gif.A_FALL,   1'b0);
    chk("rst_B_RISE",   gif.B_RISE,   1'b0);
    chk("rst_B_FALL",   gif.B_FALL,   1'b0);
    chk("rst_BOTH_CHG", gif.BOTH_CHG, 1'b0);
    chk("rst_BLOCKED",  gif.BLOCKED,  1'b0);

    // Release: held-high inputs re-debounced, accepted on 6th edge after release
    RSTN = 1'b1;
    exp_ev(9, AR | BR | BO, 1'b1, 1'b1, 1'b0);
    at(10); gif.RAW_A = 1'b0; gif.RAW_B = 1'b0;
    exp_ev(16, AF | BF | BO, 1'b0, 1'b0, 1'b0);

    // Clean edges on A
    b = 30;
    at(b);      gif.RAW_A = 1'b1; exp_ev(b + 6,  AR, 1'b1, 1'b0, 1'b0);
    at(b + 10); gif.RAW_A = 1'b0; exp_ev(b + 16, AF, 1'b0, 1'b0, 1'b0);

    // Glitches: 3 high, 1 low, 3 high, 2 low -> nothing; then held high
    b = 60;
    at(b);      gif.RAW_A = 1'b1;
    at(b + 3);  gif.RAW_A = 1'b0;
    at(b + 4);  gif.RAW_A = 1'b1;
    at(b + 7);  gif.RAW_A = 1'b0;
    at(b + 9);  gif.RAW_A = 1'b1; exp_ev(b + 15, AR, 1'b1, 1'b0, 1'b0);
    at(b + 25); gif.RAW_A = 1'b0; exp_ev(b + 31, AF, 1'b0, 1'b0, 1'b0);

    // Car entry, 10-cycle phases
    b = 110;
    at(b);      gif.RAW_A = 1'b1; exp_ev(b + 6,  AR, 1'b1, 1'b0, 1'b0);
    at(b + 10); gif.RAW_B = 1'b1; exp_ev(b + 16, BR, 1'b1, 1'b1, 1'b0);
    at(b + 20); gif.RAW_A = 1'b0; exp_ev(b + 26, AF, 1'b0, 1'b1, 1'b0);
    at(b + 30); gif.RAW_B = 1'b0; exp_ev(b + 36, BF, 1'b0, 1'b0, 1'b0);

    // Simultaneous changes, same and opposite directions
    b = 160;
    at(b);      gif.RAW_A = 1'b1; gif.RAW_B = 1'b1;
    exp_ev(b + 6, AR | BR | BO, 1'b1, 1'b1, 1'b0);
    at(b + 10); gif.RAW_A = 1'b0; gif.RAW_B = 1'b0;
    exp_ev(b + 16, AF | BF | BO, 1'b0, 1'b0, 1'b0);
    at(b + 20); gif.RAW_A = 1'b1; exp_ev(b + 26, AR, 1'b1, 1'b0, 1'b0);
    at(b + 30); gif.RAW_A = 1'b0; gif.RAW_B = 1'b1;
    exp_ev(b + 36, AF | BR | BO, 1'b0, 1'b1, 1'b0);
    at(b + 40); gif.RAW_B = 1'b0; exp_ev(b + 46, BF, 1'b0, 1'b0, 1'b0);

    // Block: B held 60 cycles
    b = 220;
    at(b);      gif.RAW_B = 1'b1;
    exp_ev(b + 6,  BR,   1'b0, 1'b1, 1'b0);
    exp_ev(b + 39, 5'b0, 1'b0, 1'b1, 1'b1);
    at(b + 60); gif.RAW_B = 1'b0;
    exp_ev(b + 66, BF,   1'b0, 1'b0, 1'b1);
    exp_ev(b + 67, 5'b0, 1'b0, 1'b0, 1'b0);

    // Reset pulse mid-block, then block again from a cleared counter
    b = 300;
    at(b);      gif.RAW_B = 1'b1;
    exp_ev(b + 6,  BR,   1'b0, 1'b1, 1'b0);
    exp_ev(b + 39, 5'b0, 1'b0, 1'b1, 1'b1);
    at(b + 45); RSTN = 1'b0;
    exp_ev(b + 46, 5'b0, 1'b0, 1'b0, 1'b0);
    at(b + 46); RSTN = 1'b1;
    exp_ev(b + 52, BR,   1'b0, 1'b1, 1'b0);
    exp_ev(b + 85, 5'b0, 1'b0, 1'b1, 1'b1);
    at(b + 90); gif.RAW_B = 1'b0;
    exp_ev(b + 96, BF,   1'b0, 1'b0, 1'b1);
    exp_ev(b + 97, 5'b0, 1'b0, 1'b0, 1'b0);

    // Drain with a bounded wait, then confirm no expected event went missing
    at(410);
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d still pending, required 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sensor_conditioner.md
# gate_sensor_conditioner

Input conditioning stage for the parking-lot gate sensors. It synchronises the two raw beam signals (A = outer, B = inner) to CLOCK_50 and debounces them. It delivers clean levels plus single-cycle edge pulses to the parking-lot FSM, which consumes A_LVL/B_LVL as its SIG_A/SIG_B. It also flags two sensor faults: simultaneous A/B transitions, and a beam obstructed for too long.

## Interface
- DB_CYCLES, 250000: consecutive synchronised-mismatch cycles required to accept a new level (5 ms at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 18: debounce counter width.
- BLOCK_CYCLES, 50000000: consecutive cycles with A_LVL or B_LVL high before BLOCKED asserts (1 s); legal range 1..2^BLK_W-1.
- BLK_W, 26: block counter width.

- CLOCK_50  in  1  single system clock; all flops on its rising edge.
- RSTN  in  1  synchronous, active-low reset.
- RAW_A  in  1  asynchronous beam A, 1 = beam interrupted.
- RAW_B  in  1  asynchronous beam B, 1 = beam interrupted.
- A_LVL  out  1  debounced level of A.
- B_LVL  out  1  debounced level of B.
- A_RISE, A_FALL  out  1 each  one-cycle pulse on each accepted A transition.
- B_RISE, B_FALL  out  1 each  one-cycle pulse on each accepted B transition.
- BOTH_CHG  out  1  one-cycle pulse when A_LVL and B_LVL change on the same edge.
- BLOCKED  out  1  level; a beam has been interrupted for at least BLOCK_CYCLES.

## Operation
- Per channel: two-flop synchroniser (s1, s2), then debounce state {lvl, cnt}.
- Debounce, evaluated each edge:
  - if s2 == lvl: cnt <= 0.
  - else if cnt == DB_CYCLES-1: lvl <= s2, cnt <= 0, fire the RISE pulse (s2=1) or FALL pulse (s2=0).
  - else: cnt <= cnt+1.
- Glitch filter: a mismatch that returns to lvl before acceptance resets cnt. Partial counts never accumulate across glitches.
- Channels are fully independent. BOTH_CHG = (A accepted transition) AND (B accepted transition) on the same edge, in any direction combination. Edge pulses still fire normally alongside BOTH_CHG.
- Block monitor, evaluated each edge on registered levels:
  - if A_LVL|B_LVL: blk_cnt increments, saturating at BLOCK_CYCLES-1; BLOCKED <= 1 on the edge where blk_cnt already equals BLOCK_CYCLES-1.
  - else: blk_cnt <= 0, BLOCKED <= 0.
- Block monitor has no effect on the A/B outputs; it is purely a status flag.
- All outputs are registered; no combinational path from RAW_* to any output.

## Timing
- Reset (RSTN=0 at an edge): s1, s2, lvl, cnt, blk_cnt and every output go to 0 at that edge. Applies mid-debounce and mid-block.
- After reset release, a RAW input already held high is re-debounced from 0 and takes the full latency.
- Latency: with RAW changed before edge 1 and held stable, lvl and the pulse update on edge DB_CYCLES+2. For DB_CYCLES=1, that is edge 3.
- Pulse width: exactly one cycle. No pulse unless lvl actually changes.
- Minimum spacing between two accepted transitions on one channel: DB_CYCLES cycles.
- BLOCKED: first high on the BLOCK_CYCLES+1-th consecutive edge that samples A_LVL|B_LVL=1. Clears on the first edge sampling both low.
- Counters never wrap: cnt resets at DB_CYCLES-1; blk_cnt saturates.

## Test plan
Bench overrides DB_CYCLES=4, BLOCK_CYCLES=32.
- Reset: RSTN=0 for 3 edges with RAW_A=RAW_B=1 -> all outputs 0; after release, A_LVL/B_LVL rise on edge 6 with A_RISE/B_RISE and BOTH_CHG pulsing once.
- Clean edge: RAW_A 0->1 held -> A_LVL=1 and A_RISE=1 on edge 6 only. RAW_A 1->0 -> A_FALL on edge 6, A_LVL=0.
- Glitches: RAW_A high 3 cycles, low 1 cycle, high 3 cycles -> A_LVL stays 0 with no pulses. Then RAW_A held high -> accepted 6 edges after the final rise.
- Car entry, 10-cycle phases (A=1; B=1; A=0; B=0) -> pulses in order A_RISE, B_RISE, A_FALL, B_FALL, spaced 10 cycles; BOTH_CHG never high; BLOCKED stays 0.
- Simultaneous change: RAW_A and RAW_B 0->1 in the same cycle -> both levels rise on the same edge; BOTH_CHG is high for exactly that cycle.
- Block/reset: RAW_B held high 60 cycles -> BLOCKED rises 33 edges after B_LVL rises and stays high. RAW_B=0 -> BLOCKED clears on the edge B_LVL falls + 1. Pulse RSTN mid-block -> BLOCKED and blk_cnt clear at that edge.
